store_write_unit: RTL and testbench

Parametrised successor to the memory write-data selector in the multicycle datapath. It selects one of N_SRC source buses and registers the selection. For sub-word stores (byte/half) it performs a read-modify-write sequence against data memory: it reads the target word, merges the selected bytes at the addressed lane, and writes the result back. It sits between the datapath source buses and the data memory port, and is driven by the control unit with a start pulse.

---
 rtl/store_write_unit.sv | 100 ++++++++++
 tb/tb_store_write_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/store_write_unit.sv
// store_write_unit: registers a selected source bus and writes it to memory,
// using read-modify-write to merge byte/half stores into the addressed word.
module store_write_unit #(
    parameter int WIDTH   = 32,
    parameter int N_SRC   = 3,
    parameter int SEL_W   = 2,
    parameter int MEM_LAT = 1,
    localparam int OFF_W  = $clog2(WIDTH / 8)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [1:0]             size,
    input  logic [OFF_W-1:0]       byte_off,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int NB    = WIDTH / 8;
    localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] MERGE = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0]       state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] src_q, sel_data, lane, mask, merged;
    logic [1:0]       size_q;
    logic [OFF_W-1:0] off_q;
    logic             accept, bad, go;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++)
            if (32'(src_sel) == i) sel_data = src_data[i*WIDTH +: WIDTH];
    end

    // a half store must start on an even lane and fit entirely inside the word
    assign bad = 32'(src_sel) >= N_SRC || size == 2'b11 ||
                 (size == 2'b00 && byte_off != '0) ||
                 (size == 2'b01 && (byte_off[0] || 32'(byte_off) >= NB - 1));
    // the done cycle also accepts a new request so stores can run back-to-back
    assign accept = start && (state == IDLE || state == WRITE);
    assign go     = accept && !bad;

    assign lane   = size_q == 2'b01 ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF);
    assign mask   = lane << {off_q, 3'b000};
    assign merged = (mem_rdata & ~mask) | ((src_q << {off_q, 3'b000}) & mask);

    always_comb begin
        case (state)
            IDLE, WRITE: nxt = go ? (size == 2'b00 ? WRITE : READ) : IDLE;
            READ:        nxt = MEM_LAT > 1 ? WAIT : MERGE;
            WAIT:        nxt = cnt == CNT_LAST ? MERGE : WAIT;
            MERGE:       nxt = WRITE;
            default:     nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            src_q     <= '0;
            size_q    <= '0;
            off_q     <= '0;
        end else begin
            state  <= nxt;
            cnt    <= state == WAIT ? cnt + 1'b1 : '0;
            mem_rd <= nxt == READ;
            mem_wr <= nxt == WRITE;
            done   <= nxt == WRITE;
            busy   <= nxt != IDLE;
            err    <= accept && bad;
            if (go) begin
                src_q  <= sel_data;
                size_q <= size;
                off_q  <= byte_off;
            end
            // MERGE is the cycle in which read data is valid; it is folded in on the way to WRITE
            if (go && size == 2'b00) mem_wdata <= sel_data;
            else if (state == MERGE) mem_wdata <= merged;
        end
    end
endmodule

// File: tb/tb_store_write_unit.sv
// tb_store_write_unit: directed and random store sequences on a MEM_LAT=1 and a
// MEM_LAT=3 instance, checked against a byte-level reference model.
module tb_store_write_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  src_sel = '0, size = '0, byte_off = '0;
    logic [95:0] src_data = '0;
    logic [31:0] mem_rdata_a = '0, mem_rdata_b = '0, mem_word_a = '0, mem_word_b = '0;
    logic        rd_a, wr_a, busy_a, done_a, err_a, rd_b, wr_b, busy_b, done_b, err_b;
    logic [31:0] wd_a, wd_b;
    logic [31:0] last_wd [2];
    int          age_a = 100, age_b = 100;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    store_write_unit #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .src_sel(src_sel), .src_data(src_data),
        .size(size), .byte_off(byte_off), .mem_rdata(mem_rdata_a), .mem_rd(rd_a), .mem_wr(wr_a),
        .mem_wdata(wd_a), .busy(busy_a), .done(done_a), .err(err_a));

    store_write_unit #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .src_sel(src_sel), .src_data(src_data),
        .size(size), .byte_off(byte_off), .mem_rdata(mem_rdata_b), .mem_rd(rd_b), .mem_wr(wr_b),
        .mem_wdata(wd_b), .busy(busy_b), .done(done_b), .err(err_b));

    // memory: read data is valid only MEM_LAT cycles after the strobe cycle, garbage otherwise
    always @(negedge clk) begin
        age_a = rd_a ? 0 : (age_a < 100 ? age_a + 1 : 100);
        age_b = rd_b ? 0 : (age_b < 100 ? age_b + 1 : 100);
        mem_rdata_a = age_a == 1 ? mem_word_a : $urandom;
        mem_rdata_b = age_b == 3 ? mem_word_b : $urandom;
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_bad(int sel, int sz, int off);
        return sel >= 3 || sz == 3 || (sz == 0 && off != 0) || (sz == 1 && (off % 2 == 1 || off + 2 > 4));
    endfunction

    function automatic logic [31:0] model_wdata(logic [95:0] srcs, int sel, int sz, int off, logic [31:0] mword);
        logic [95:0] sh = srcs >> (32 * sel);
        logic [31:0] src = sh[31:0];
        logic [7:0]  mb [4];
        int          n = sz == 2 ? 1 : 2;
        if (sz == 0) return src;
        for (int i = 0; i < 4; i++) mb[i] = mword[8*i +: 8];
        for (int k = 0; k < n; k++) mb[off + k] = src[8*k +: 8];
        return {mb[3], mb[2], mb[1], mb[0]};
    endfunction

    task automatic set_start(int d, logic v);
        if (d == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic run_op(int d, int sel, int sz, int off, logic [95:0] srcs, logic [31:0] mword, bit extra);
        int          lat = d == 0 ? 1 : 3;
        bit          bad = model_bad(sel, sz, off);
        bit          ex = extra && !bad && sz != 0;
        logic [31:0] exp_wd = bad ? last_wd[d] : model_wdata(srcs, sel, sz, off, mword);
        int          exp_wr = bad ? 0 : (sz == 0 ? 1 : 2 + lat);
        int          exp_rd = (bad || sz == 0) ? 0 : 1;
        int          first_rd = 0, first_wr = 0, n_rd = 0, n_wr = 0, n_err = 0, err_cyc = 0;
        int          n_busy = 0, clash = 0, mis = 0;
        logic        rd, wr, dn, er, bs;
        logic [31:0] wd, wd_at_wr = '0, wd_end = '0;
        if (d == 0) mem_word_a = mword;
        else mem_word_b = mword;
        src_data = srcs; src_sel = 2'(sel); size = 2'(sz); byte_off = 2'(off);
        set_start(d, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            rd = d == 0 ? rd_a : rd_b;   wr = d == 0 ? wr_a : wr_b;
            dn = d == 0 ? done_a : done_b; er = d == 0 ? err_a : err_b;
            bs = d == 0 ? busy_a : busy_b; wd = d == 0 ? wd_a : wd_b;
            if (rd) begin n_rd++; if (first_rd == 0) first_rd = c; end
            if (wr) begin n_wr++; if (first_wr == 0) begin first_wr = c; wd_at_wr = wd; end end
            if (er) begin n_err++; err_cyc = c; end
            if (bs && c != exp_wr) n_busy++;
            if (rd && wr) clash++;
            if (dn !== wr) mis++;
            if (c == 9) wd_end = wd;
            if (c == 1) begin
                set_start(d, ex);
                src_data = {$urandom, $urandom, $urandom};
                src_sel = 2'($urandom); size = 2'($urandom); byte_off = 2'($urandom);
            end else set_start(d, 1'b0);
        end
        chk("err_count", n_err, bad ? 1 : 0);
        chk("err_cycle", err_cyc, bad ? 1 : 0);
        chk("rd_count", n_rd, exp_rd);
        chk("rd_cycle", first_rd, exp_rd);
        chk("wr_count", n_wr, bad ? 0 : 1);
        chk("wr_cycle", first_wr, exp_wr);
        chk("busy_cycles", n_busy, bad ? 0 : exp_wr - 1);
        chk("rd_wr_clash", clash, 0);
        chk("done_vs_wr", mis, 0);
        if (!bad) chk("wdata", wd_at_wr, exp_wd);
        chk("wdata_hold", wd_end, exp_wd);
        last_wd[d] = exp_wd;
    endtask

    initial begin
        logic [31:0] wexp;
        int          n;
        last_wd[0] = '0; last_wd[1] = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs_a", {rd_a, wr_a, busy_a, done_a, err_a}, 0);
        chk("reset_outs_b", {rd_b, wr_b, busy_b, done_b, err_b}, 0);
        chk("reset_wdata", {wd_a, wd_b}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op(0, 1, 0, 0, {32'hC0C0C0C0, 32'hDEADBEEF, 32'hA0A0A0A0}, 32'h0, 1'b0);
        chk("tp1_wdata", wd_a, 32'hDEADBEEF);
        run_op(0, 0, 2, 2, {32'h0, 32'h0, 32'h000000AB}, 32'h11223344, 1'b0);
        chk("tp2_wdata", wd_a, 32'h11AB3344);
        run_op(1, 2, 1, 2, {32'hFFFF5A5A, 32'h0, 32'h0}, 32'h11223344, 1'b0);
        chk("tp3_wdata", wd_b, 32'h5A5A3344);

        run_op(0, 3, 0, 0, {3{32'h12345678}}, 32'h0, 1'b0);
        run_op(0, 0, 3, 0, {3{32'h12345678}}, 32'h0, 1'b0);
        run_op(0, 0, 1, 1, {3{32'h12345678}}, 32'h0, 1'b0);
        run_op(0, 0, 0, 2, {3{32'h12345678}}, 32'h0, 1'b0);
        run_op(1, 1, 1, 3, {3{32'h12345678}}, 32'h0, 1'b0);

        // a second start during a byte store must be ignored
        run_op(0, 1, 2, 3, {32'h0, 32'h00000077, 32'h0}, 32'hCAFEF00D, 1'b1);

        // back-to-back: start during the done cycle of a byte store launches a word store
        mem_word_a = 32'hA5A5A5A5;
        src_data = {32'h0, 32'h0, 32'h00000042}; src_sel = 2'd0; size = 2'd2; byte_off = 2'd1;
        start_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (c == 3) begin
                chk("b2b_done1", {done_a, wr_a}, 2'b11);
                chk("b2b_wdata1", wd_a, model_wdata({32'h0, 32'h0, 32'h00000042}, 0, 2, 1, 32'hA5A5A5A5));
                src_data = {32'h13572468, 32'h0, 32'h0}; src_sel = 2'd2; size = 2'd0; byte_off = 2'd0;
                start_a = 1'b1;
            end
            if (c == 4) begin
                chk("b2b_done2", {done_a, wr_a, rd_a}, 3'b110);
                chk("b2b_wdata2", wd_a, 32'h13572468);
            end
            if (c == 5) chk("b2b_idle", {done_a, wr_a, busy_a}, 0);
        end
        last_wd[0] = 32'h13572468;

        // reset abort while the MEM_LAT=3 instance waits for read data
        mem_word_b = 32'h55667788;
        src_data = {32'h0, 32'h000000EE, 32'h0}; src_sel = 2'd1; size = 2'd2; byte_off = 2'd0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", busy_b, 1);
        reset = 1'b0;
        #1;
        chk("abort_outs", {rd_b, wr_b, busy_b, done_b, err_b}, 0);
        chk("abort_wdata", wd_b, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n += int'(wr_b) + int'(busy_b);
        end
        chk("abort_no_wr", n, 0);
        last_wd[0] = '0; last_wd[1] = '0;
        run_op(1, 0, 0, 0, {32'h0, 32'h0, 32'h0BADF00D}, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(i % 2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   {$urandom, $urandom, $urandom}, $urandom, i % 4 == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
